// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared picture-pipeline constants, RGB565 colors and write-arbiter state type
package pic_pkg;

    localparam int IMAGE_H    = 98;
    localparam int IMAGE_W    = 98;
    localparam int IMAGE_SIZE = IMAGE_H * IMAGE_W;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    typedef enum logic [2:0] {
        IDLE,
        GRANT0,
        GRANT1,
        COMMIT,
        ABORT
    } arb_state_t;

endpackage

// File: rtl/beat_watchdog.sv
// rtl/beat_watchdog.sv - reloadable down-counter flagging TIMEOUT enabled cycles without a reload
module beat_watchdog #(
    parameter int               WIDTH   = 24,
    parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(5_000_000)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_en,
    input  logic i_reload,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LOAD = TIMEOUT - WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Held at LOAD while disabled, so the first enabled cycle already counts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= LOAD;
        end else if (!i_en || i_reload) begin
            r_cnt <= LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_expired = i_en && !i_reload && (r_cnt == '0);

endmodule

// File: rtl/pic_wr_arb.sv
// rtl/pic_wr_arb.sv - frame-level arbiter and write controller for the ping-pong picture RAM
module pic_wr_arb
    import pic_pkg::*;
#(
    parameter int          IMAGE_SIZE = pic_pkg::IMAGE_SIZE,
    parameter int          ADDR_W     = pic_pkg::ADDR_W,
    parameter int          DATA_W     = pic_pkg::DATA_W,
    parameter logic [23:0] TIMEOUT    = 24'd5_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_s0_req,
    input  logic              i_s0_valid,
    input  logic [DATA_W-1:0] i_s0_data,
    output logic              o_s0_ready,
    input  logic              i_s1_req,
    input  logic              i_s1_valid,
    input  logic [DATA_W-1:0] i_s1_data,
    output logic              o_s1_ready,
    output logic              o_s0_grant,
    output logic              o_s1_grant,
    output logic              o_ram_wren,
    output logic              o_ram_wr_bank,
    output logic [ADDR_W-1:0] o_ram_wraddr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_disp_bank,
    output logic              o_frame_done,
    output logic              o_frame_abort,
    output logic              o_frame_src
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_src;
    logic              r_disp_bank;
    logic              r_frame_done;
    logic              r_frame_abort;
    logic              r_frame_src;
    logic              r_ram_wren;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_ram_wraddr;
    logic [DATA_W-1:0] r_ram_data;
    logic              w_s0_ready;
    logic              w_s1_ready;
    logic              w_wd_en;
    logic              w_beat;
    logic              w_last;
    logic              w_expired;
    logic [DATA_W-1:0] w_beat_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A completing beat wins over a same-cycle req drop or watchdog expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_s0_req && i_s1_req) begin
                    w_next_state = r_last_src ? GRANT0 : GRANT1;
                end else if (i_s0_req) begin
                    w_next_state = GRANT0;
                end else if (i_s1_req) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT0: begin
                if (w_beat && w_last) begin
                    w_next_state = COMMIT;
                end else if (!i_s0_req || w_expired) begin
                    w_next_state = ABORT;
                end
            end
            GRANT1: begin
                if (w_beat && w_last) begin
                    w_next_state = COMMIT;
                end else if (!i_s1_req || w_expired) begin
                    w_next_state = ABORT;
                end
            end
            COMMIT:  w_next_state = IDLE;
            ABORT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_s0_ready = 1'b0;
        w_s1_ready = 1'b0;
        case (r_state)
            GRANT0:  w_s0_ready = 1'b1;
            GRANT1:  w_s1_ready = 1'b1;
            default: ;
        endcase
        w_wd_en = w_s0_ready | w_s1_ready;
    end

    assign w_beat      = (w_s0_ready & i_s0_valid) | (w_s1_ready & i_s1_valid);
    assign w_beat_data = w_s1_ready ? i_s1_data : i_s0_data;
    assign w_last      = (r_wr_cnt == LAST_ADDR);

    beat_watchdog #(
        .WIDTH   (24),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_en      (w_wd_en),
        .i_reload  (w_beat),
        .o_expired (w_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_src    <= 1'b1;
            r_disp_bank   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_frame_src   <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_wr_cnt      <= '0;
            r_ram_wraddr  <= '0;
            r_ram_data    <= '0;
        end else begin
            r_ram_wren    <= w_beat;
            r_frame_done  <= (r_state == COMMIT);
            r_frame_abort <= (r_state == ABORT);
            if (w_beat) begin
                r_ram_wraddr <= r_wr_cnt;
                r_ram_data   <= w_beat_data;
            end
            // Every grant is entered from IDLE, so clearing here restarts each frame at 0.
            if (r_state == IDLE) begin
                r_wr_cnt <= '0;
            end else if (w_beat && !w_last) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (r_state == IDLE && w_next_state == GRANT0) begin
                r_last_src <= 1'b0;
            end else if (r_state == IDLE && w_next_state == GRANT1) begin
                r_last_src <= 1'b1;
            end
            if (r_state == COMMIT) begin
                r_disp_bank <= ~r_disp_bank;
                r_frame_src <= r_last_src;
            end
        end
    end

    assign o_s0_ready    = w_s0_ready;
    assign o_s1_ready    = w_s1_ready;
    assign o_s0_grant    = w_s0_ready;
    assign o_s1_grant    = w_s1_ready;
    assign o_ram_wren    = r_ram_wren;
    assign o_ram_wr_bank = ~r_disp_bank;
    assign o_ram_wraddr  = r_ram_wraddr;
    assign o_ram_data    = r_ram_data;
    assign o_disp_bank   = r_disp_bank;
    assign o_frame_done  = r_frame_done;
    assign o_frame_abort = r_frame_abort;
    assign o_frame_src   = r_frame_src;

endmodule

// File: tb/tb_pic_wr_arb.sv
// tb/tb_pic_wr_arb.sv - directed self-checking bench for pic_wr_arb
module tb_pic_wr_arb;

    localparam int NPIX = 9604;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        s0_req, s0_valid, s1_req, s1_valid;
    logic [15:0] s0_data, s1_data;
    logic        s0_ready, s1_ready, s0_grant, s1_grant;
    logic        ram_wren, ram_wr_bank, disp_bank, frame_done, frame_abort, frame_src;
    logic [13:0] ram_wraddr;
    logic [15:0] ram_data;

    int   n_vec = 0;
    int   n_err = 0;
    int   wr_seen, wr_bad, done_seen, abort_seen, rdy0_seen;
    int   exp_addr;
    logic exp_bank;
    int   cur_src;

    always #5 sys_clk = ~sys_clk;

    pic_wr_arb #(.TIMEOUT(24'd100)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .i_s0_req      (s0_req),
        .i_s0_valid    (s0_valid),
        .i_s0_data     (s0_data),
        .o_s0_ready    (s0_ready),
        .i_s1_req      (s1_req),
        .i_s1_valid    (s1_valid),
        .i_s1_data     (s1_data),
        .o_s1_ready    (s1_ready),
        .o_s0_grant    (s0_grant),
        .o_s1_grant    (s1_grant),
        .o_ram_wren    (ram_wren),
        .o_ram_wr_bank (ram_wr_bank),
        .o_ram_wraddr  (ram_wraddr),
        .o_ram_data    (ram_data),
        .o_disp_bank   (disp_bank),
        .o_frame_done  (frame_done),
        .o_frame_abort (frame_abort),
        .o_frame_src   (frame_src)
    );

    function automatic logic [15:0] beat_data(input int src, input int k);
        logic [15:0] v;
        v = 16'(k);
        return (src == 1) ? (v ^ 16'h5A5A) : v;
    endfunction

    task automatic clear_counts();
        wr_seen = 0; wr_bad = 0; done_seen = 0; abort_seen = 0; rdy0_seen = 0;
    endtask

    // Advance to the next falling edge and tally what the DUT presented during that cycle.
    task automatic cyc();
        @(negedge sys_clk);
        if (ram_wren) begin
            wr_seen++;
            if (ram_wraddr !== 14'(exp_addr) || ram_data !== beat_data(cur_src, exp_addr)
                || ram_wr_bank !== exp_bank)
                wr_bad++;
            exp_addr++;
        end
        if (frame_done)  done_seen++;
        if (frame_abort) abort_seen++;
        if (s0_ready)    rdy0_seen++;
    endtask

    // Stream beats first..last-1 from src with valid held; returns one cycle after the last accept.
    task automatic feed(input int src, input int first, input int last);
        int k;
        int guard;
        k = first;
        guard = 0;
        if (src == 0) s0_req = 1'b1; else s1_req = 1'b1;
        while (k < last && guard < (last - first) + 200) begin
            cyc();
            if (src == 0) begin
                s0_valid = 1'b1; s0_data = beat_data(0, k);
                if (s0_ready) k++;
            end else begin
                s1_valid = 1'b1; s1_data = beat_data(1, k);
                if (s1_ready) k++;
            end
            guard++;
        end
        n_vec++;
        if (k != last) begin
            n_err++;
            $display("FAIL feed_src%0d: accepted up to beat %0d, required %0d", src, k, last);
        end
        cyc();
        if (src == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        s0_req = 0; s0_valid = 0; s0_data = '0;
        s1_req = 0; s1_valid = 0; s1_data = '0;
        exp_addr = 0; exp_bank = 1'b1; cur_src = 0;
        clear_counts();
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if ({s0_grant, s1_grant, s0_ready, s1_ready, ram_wren, frame_done, frame_abort} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 0000000",
                {s0_grant, s1_grant, s0_ready, s1_ready, ram_wren, frame_done, frame_abort});
        end
        n_vec++;
        if (disp_bank !== 1'b0 || ram_wr_bank !== 1'b1 || frame_src !== 1'b0) begin
            n_err++; $display("FAIL reset_banks: disp/wr_bank/src %b%b%b required 010",
                disp_bank, ram_wr_bank, frame_src);
        end
        n_vec++;
        if (ram_wraddr !== 14'd0 || ram_data !== 16'd0) begin
            n_err++; $display("FAIL reset_wpath: addr %0d data %h required 0 0000", ram_wraddr, ram_data);
        end
        sys_rst_n = 1'b1;
        cyc();
        n_vec++;
        if (s0_grant !== 1'b0 || s1_grant !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req: grants %b%b required 00", s0_grant, s1_grant);
        end
    endtask

    task automatic test_single_s0();
        clear_counts(); cur_src = 0; exp_addr = 0; exp_bank = 1'b1;
        s0_req = 1'b1;
        cyc();
        n_vec++;
        if (s0_grant !== 1'b1 || s0_ready !== 1'b1 || s1_grant !== 1'b0) begin
            n_err++; $display("FAIL grant_latency: s0_grant %b s0_ready %b s1_grant %b required 1 1 0",
                s0_grant, s0_ready, s1_grant);
        end
        feed(0, 0, NPIX);
        s0_req = 1'b0;
        n_vec++;
        if (disp_bank !== 1'b0 || frame_done !== 1'b0 || s0_ready !== 1'b0) begin
            n_err++; $display("FAIL commit_cycle: disp %b done %b ready %b required 0 0 0",
                disp_bank, frame_done, s0_ready);
        end
        cyc();
        n_vec++;
        if (frame_done !== 1'b1 || disp_bank !== 1'b1 || frame_src !== 1'b0 || ram_wr_bank !== 1'b0) begin
            n_err++; $display("FAIL single_commit: done %b disp %b src %b wr_bank %b required 1 1 0 0",
                frame_done, disp_bank, frame_src, ram_wr_bank);
        end
        repeat (3) cyc();
        n_vec++;
        if (wr_seen != NPIX || wr_bad != 0 || done_seen != 1 || abort_seen != 0) begin
            n_err++; $display("FAIL single_writes: writes %0d bad %0d done %0d abort %0d required %0d 0 1 0",
                wr_seen, wr_bad, done_seen, abort_seen, NPIX);
        end
    endtask

    task automatic test_tie();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_counts(); cur_src = 0; exp_addr = 0; exp_bank = 1'b1;
        s0_req = 1'b1; s1_req = 1'b1;
        cyc();
        n_vec++;
        if (s0_grant !== 1'b1 || s1_grant !== 1'b0) begin
            n_err++; $display("FAIL tie_first: grants s0 %b s1 %b required 1 0", s0_grant, s1_grant);
        end
        feed(0, 0, NPIX);
        s0_req = 1'b0;
        cur_src = 1; exp_addr = 0; exp_bank = 1'b0;
        cyc();
        n_vec++;
        if (s1_grant !== 1'b0 || disp_bank !== 1'b1 || frame_src !== 1'b0) begin
            n_err++; $display("FAIL tie_gap: s1_grant %b disp %b src %b required 0 1 0",
                s1_grant, disp_bank, frame_src);
        end
        cyc();
        n_vec++;
        if (s1_grant !== 1'b1) begin
            n_err++; $display("FAIL tie_second: s1_grant %b required 1", s1_grant);
        end
        feed(1, 0, NPIX);
        s1_req = 1'b0;
        cyc();
        n_vec++;
        if (disp_bank !== 1'b0 || frame_src !== 1'b1 || frame_done !== 1'b1) begin
            n_err++; $display("FAIL tie_commit2: disp %b src %b done %b required 0 1 1",
                disp_bank, frame_src, frame_done);
        end
        repeat (3) cyc();
        n_vec++;
        if (wr_seen != 2 * NPIX || wr_bad != 0 || done_seen != 2) begin
            n_err++; $display("FAIL tie_writes: writes %0d bad %0d done %0d required %0d 0 2",
                wr_seen, wr_bad, done_seen, 2 * NPIX);
        end
    endtask

    task automatic test_contention();
        clear_counts(); cur_src = 1; exp_addr = 0; exp_bank = 1'b1;
        s1_req = 1'b1;
        cyc();
        n_vec++;
        if (s1_grant !== 1'b1) begin
            n_err++; $display("FAIL cont_grant1: s1_grant %b required 1", s1_grant);
        end
        feed(1, 0, 100);
        s0_req = 1'b1; s0_valid = 1'b1; s0_data = 16'hDEAD;
        feed(1, 100, NPIX);
        s1_req = 1'b0;
        n_vec++;
        if (rdy0_seen != 0) begin
            n_err++; $display("FAIL cont_s0_blocked: s0_ready high %0d cycles required 0", rdy0_seen);
        end
        cyc();
        n_vec++;
        if (s0_grant !== 1'b0) begin
            n_err++; $display("FAIL cont_gap: s0_grant %b required 0", s0_grant);
        end
        cyc();
        n_vec++;
        if (s0_grant !== 1'b1) begin
            n_err++; $display("FAIL cont_s0_next: s0_grant %b required 1", s0_grant);
        end
        s0_req = 1'b0; s0_valid = 1'b0;
        repeat (2) cyc();
        n_vec++;
        if (frame_abort !== 1'b1 || disp_bank !== 1'b1 || wr_seen != NPIX || wr_bad != 0) begin
            n_err++; $display("FAIL cont_end: abort %b disp %b writes %0d bad %0d required 1 1 %0d 0",
                frame_abort, disp_bank, wr_seen, wr_bad, NPIX);
        end
    endtask

    task automatic test_timeout();
        clear_counts(); cur_src = 0; exp_addr = 0; exp_bank = 1'b0;
        s0_req = 1'b1;
        feed(0, 0, 5000);
        repeat (99) cyc();
        n_vec++;
        if (s0_grant !== 1'b1 || abort_seen != 0) begin
            n_err++; $display("FAIL wd_not_early: grant %b aborts %0d required 1 0", s0_grant, abort_seen);
        end
        cyc();
        n_vec++;
        if (s0_grant !== 1'b0 || frame_abort !== 1'b0) begin
            n_err++; $display("FAIL wd_abort_state: grant %b abort %b required 0 0", s0_grant, frame_abort);
        end
        cyc();
        n_vec++;
        if (frame_abort !== 1'b1) begin
            n_err++; $display("FAIL wd_abort_pulse: abort %b required 1", frame_abort);
        end
        s0_req = 1'b0;
        repeat (3) cyc();
        n_vec++;
        if (abort_seen != 1 || done_seen != 0 || disp_bank !== 1'b1 || wr_seen != 5000 || wr_bad != 0) begin
            n_err++; $display("FAIL wd_end: aborts %0d done %0d disp %b writes %0d bad %0d required 1 0 1 5000 0",
                abort_seen, done_seen, disp_bank, wr_seen, wr_bad);
        end
    endtask

    task automatic test_req_drop();
        clear_counts(); cur_src = 1; exp_addr = 0; exp_bank = 1'b0;
        s1_req = 1'b1;
        feed(1, 0, 20);
        s1_valid = 1'b1; s1_data = beat_data(1, 20); s1_req = 1'b0;
        cyc();
        s1_valid = 1'b0;
        n_vec++;
        if (s1_grant !== 1'b0 || s1_ready !== 1'b0 || ram_wren !== 1'b1) begin
            n_err++; $display("FAIL drop_state: grant %b ready %b wren %b required 0 0 1",
                s1_grant, s1_ready, ram_wren);
        end
        cyc();
        n_vec++;
        if (frame_abort !== 1'b1 || wr_seen != 21) begin
            n_err++; $display("FAIL drop_abort: abort %b writes %0d required 1 21", frame_abort, wr_seen);
        end
        exp_addr = 0;
        s1_req = 1'b1;
        feed(1, 0, 30);
        s1_req = 1'b0;
        repeat (3) cyc();
        n_vec++;
        if (wr_seen != 51 || wr_bad != 0 || abort_seen != 2 || done_seen != 0 || disp_bank !== 1'b1) begin
            n_err++; $display("FAIL drop_restart: writes %0d bad %0d aborts %0d done %0d disp %b required 51 0 2 0 1",
                wr_seen, wr_bad, abort_seen, done_seen, disp_bank);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts(); cur_src = 0; exp_addr = 0; exp_bank = 1'b0;
        s0_req = 1'b1;
        feed(0, 0, 4000);
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({s0_grant, s1_grant, s0_ready, s1_ready, ram_wren, frame_done, frame_abort} !== 7'b0
            || disp_bank !== 1'b0 || ram_wr_bank !== 1'b1 || frame_src !== 1'b0
            || ram_wraddr !== 14'd0 || ram_data !== 16'd0) begin
            n_err++; $display("FAIL mid_reset: ctrl %b disp %b wr_bank %b src %b addr %0d data %h required 0000000 0 1 0 0 0000",
                {s0_grant, s1_grant, s0_ready, s1_ready, ram_wren, frame_done, frame_abort},
                disp_bank, ram_wr_bank, frame_src, ram_wraddr, ram_data);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_addr = 0; exp_bank = 1'b1;
        feed(0, 0, NPIX);
        s0_req = 1'b0;
        cyc();
        n_vec++;
        if (frame_done !== 1'b1 || disp_bank !== 1'b1 || frame_src !== 1'b0) begin
            n_err++; $display("FAIL post_reset_commit: done %b disp %b src %b required 1 1 0",
                frame_done, disp_bank, frame_src);
        end
        repeat (3) cyc();
        n_vec++;
        if (wr_seen != 4000 + NPIX || wr_bad != 0 || done_seen != 1 || abort_seen != 0) begin
            n_err++; $display("FAIL post_reset_writes: writes %0d bad %0d done %0d abort %0d required %0d 0 1 0",
                wr_seen, wr_bad, done_seen, abort_seen, 4000 + NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_single_s0();
        test_tie();
        test_contention();
        test_timeout();
        test_req_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
